// File: rtl/tconv_pkg.sv
// Shared types and ternary arithmetic for the 3x3 ternary window stage.
// Ternary code: 00 = 0, 01 = +1, 11 = -1, 10 = 0.
package tconv_pkg;

  localparam logic [1:0] TERN_ZERO = 2'b00;
  localparam logic [1:0] TERN_POS  = 2'b01;
  localparam logic [1:0] TERN_NEG  = 2'b11;

  localparam int WGT_W = 18;
  localparam int SUM_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROW   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic signed [1:0] tern_mul(input logic [1:0] a, input logic [1:0] b);
    logic a_nz, b_nz;
    a_nz = (a == TERN_POS) || (a == TERN_NEG);
    b_nz = (b == TERN_POS) || (b == TERN_NEG);
    if (!(a_nz && b_nz)) return 2'sb00;
    return (a == b) ? 2'sb01 : 2'sb11;
  endfunction

  // d and w are {left, centre, right} codes of one window row
  function automatic logic signed [2:0] row_sum3(input logic [5:0] d, input logic [5:0] w);
    logic signed [1:0] m0, m1, m2;
    m0 = tern_mul(d[5:4], w[5:4]);
    m1 = tern_mul(d[3:2], w[3:2]);
    m2 = tern_mul(d[1:0], w[1:0]);
    return $signed({m0[1], m0}) + $signed({m1[1], m1}) + $signed({m2[1], m2});
  endfunction

endpackage

// File: rtl/tconv_window3x3_chan_delay_line.sv
// Per-channel column delay: CHANNEL-deep RAM, combinational read of the old
// word while the same address is written at the clock edge.
module chan_delay_line #(
  parameter int CHANNEL = 128,
  parameter int WIDTH   = 6,
  parameter int AW      = (CHANNEL > 1) ? $clog2(CHANNEL) : 1
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [CHANNEL];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/tconv_window3x3.sv
// Horizontally padded 3x3 ternary window and dot product over a channel-interleaved
// column stream. Optional protocol error flag o_err under `TCONV_PROTO_ERR_EN.
module tconv_window3x3
  import tconv_pkg::*;
#(
  parameter int SIZE    = 28,
  parameter int CHANNEL = 128,
  parameter int LEN     = 3,
  parameter int CW      = (CHANNEL > 1) ? $clog2(CHANNEL) : 1
) (
  input  logic             i_sclk,
  input  logic             i_rst,
  input  logic             i_vsync,
  input  logic             i_hsync,
  input  logic             i_valid,
  input  logic [2*LEN-1:0] i_tdata,
  output logic [CW-1:0]    o_wch,
  input  logic [WGT_W-1:0] i_weight,
  output logic             o_vsync,
  output logic             o_hsync,
  output logic             o_valid,
  output logic [SUM_W-1:0] o_tdata,
  output logic [CW-1:0]    o_ch
`ifdef TCONV_PROTO_ERR_EN
  ,
  output logic             o_err
`endif
);

  localparam int PW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int DW     = 2 * LEN;
  localparam int STAGES = 2;

  state_t            r_state, w_next;
  logic [PW-1:0]     r_px;
  logic [CW-1:0]     r_ch, r_fidx, w_idx, r_ch1;
  logic              r_hs_pend;
  logic              w_in_row, w_in_flush, w_accept, w_last, w_flush_end;
  logic              w_fire, w_first;
  logic [DW-1:0]     w_right, w_centre, w_left, w_d2_rd;
  logic [LEN-1:0][2:0] w_rs, r_rs;
  logic [STAGES:1]   r_vld_pipe;
  logic [2:0]        r_vs_dly;

  // FSM state register
  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // FSM next state; a row start seen during FLUSH is held until the flush ends
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_hsync) w_next = ST_ROW;
      ST_ROW:   if (w_accept && w_last) w_next = ST_FLUSH;
      ST_FLUSH: if (w_flush_end) w_next = (r_hs_pend || i_hsync) ? ST_ROW : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
    if (i_vsync) w_next = ST_IDLE;
  end

  // FSM outputs
  always_comb begin
    w_in_row   = (r_state == ST_ROW);
    w_in_flush = (r_state == ST_FLUSH);
  end

  assign w_accept    = w_in_row && i_valid && !i_hsync && !i_vsync;
  assign w_last      = (r_px == PW'(SIZE - 1)) && (r_ch == CW'(CHANNEL - 1));
  assign w_flush_end = w_in_flush && (r_fidx == CW'(CHANNEL - 1));
  assign w_idx       = w_in_flush ? r_fidx : r_ch;
  assign o_wch       = w_idx;

  // Column 0 only primes D1; every later beat and every flush cycle emits the
  // result for the pixel one column to the left.
  assign w_fire  = (w_accept && (r_px != '0)) || (w_in_flush && !i_vsync);
  assign w_first = w_in_flush ? ((SIZE == 1) && (r_fidx == '0))
                              : ((r_px == PW'(1)) && (r_ch == '0));

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      r_px      <= '0;
      r_ch      <= '0;
      r_fidx    <= '0;
      r_hs_pend <= 1'b0;
    end else begin
      if (i_vsync || i_hsync) begin
        r_px <= '0;
        r_ch <= '0;
      end else if (w_accept) begin
        if (r_ch == CW'(CHANNEL - 1)) begin
          r_ch <= '0;
          r_px <= (r_px == PW'(SIZE - 1)) ? '0 : r_px + PW'(1);
        end else begin
          r_ch <= r_ch + CW'(1);
        end
      end
      if (i_vsync || !w_in_flush) r_fidx <= '0;
      else                        r_fidx <= w_flush_end ? '0 : r_fidx + CW'(1);
      if (i_vsync || !w_in_flush || w_flush_end) r_hs_pend <= 1'b0;
      else if (i_hsync)                          r_hs_pend <= 1'b1;
    end
  end

  chan_delay_line #(.CHANNEL(CHANNEL), .WIDTH(DW), .AW(CW)) u_d1 (
    .i_clk   (i_sclk),
    .i_we    (w_accept),
    .i_addr  (w_idx),
    .i_wdata (i_tdata),
    .o_rdata (w_centre)
  );

  chan_delay_line #(.CHANNEL(CHANNEL), .WIDTH(DW), .AW(CW)) u_d2 (
    .i_clk   (i_sclk),
    .i_we    (w_accept),
    .i_addr  (w_idx),
    .i_wdata (w_centre),
    .o_rdata (w_d2_rd)
  );

  // D2 still holds the previous row at px==1, so the left pad is forced here
  assign w_right = w_in_flush ? {LEN{TERN_ZERO}} : i_tdata;
  assign w_left  = ((w_in_row && (r_px == PW'(1))) || (w_in_flush && (SIZE == 1)))
                   ? {LEN{TERN_ZERO}} : w_d2_rd;

  always_comb begin
    w_rs = '0;
    for (int r = 0; r < LEN; r++)
      w_rs[r] = row_sum3({w_left[DW-1-2*r -: 2], w_centre[DW-1-2*r -: 2], w_right[DW-1-2*r -: 2]},
                         i_weight[WGT_W-1-6*r -: 6]);
  end

  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      r_rs       <= '0;
      r_ch1      <= '0;
      o_hsync    <= 1'b0;
      o_tdata    <= '0;
      o_ch       <= '0;
      r_vs_dly   <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_fire};
      o_hsync    <= w_fire && w_first;
      r_vs_dly   <= {r_vs_dly[1:0], i_vsync};
      if (w_fire) begin
        r_rs  <= w_rs;
        r_ch1 <= w_idx;
      end
      if (r_vld_pipe[1]) begin
        o_tdata <= {{2{r_rs[0][2]}}, r_rs[0]} + {{2{r_rs[1][2]}}, r_rs[1]}
                 + {{2{r_rs[2][2]}}, r_rs[2]};
        o_ch    <= r_ch1;
      end
    end
  end

  assign o_valid = r_vld_pipe[STAGES];
  assign o_vsync = r_vs_dly[2];

`ifdef TCONV_PROTO_ERR_EN
  // Beats beyond SIZE*CHANNEL land after ROW has ended, so the outside-ROW
  // check also catches an over-long row.
  always_ff @(posedge i_sclk or posedge i_rst) begin
    if (i_rst)                                          o_err <= 1'b0;
    else if (i_vsync)                                   o_err <= 1'b0;
    else if ((i_valid && !w_in_row) || (i_hsync && w_in_row)) o_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_tconv_window3x3.sv
// Scoreboarded bench for tconv_window3x3: directed and random rows checked
// against a direct padded 3x3 convolution model.
module tb_tconv_window3x3;

  localparam int SIZE    = 28;
  localparam int CHANNEL = 128;
  localparam int CW      = 7;

  logic          clk = 1'b0;
  logic          rst, vsync, hsync, valid;
  logic [5:0]    tdata;
  logic [17:0]   weight;
  logic [CW-1:0] wch, och;
  logic          ovsync, ohsync, ovalid;
  logic [4:0]    otdata;
`ifdef TCONV_PROTO_ERR_EN
  logic          oerr;
`endif

  tconv_window3x3 #(.SIZE(SIZE), .CHANNEL(CHANNEL)) dut (
    .i_sclk   (clk),
    .i_rst    (rst),
    .i_vsync  (vsync),
    .i_hsync  (hsync),
    .i_valid  (valid),
    .i_tdata  (tdata),
    .o_wch    (wch),
    .i_weight (weight),
    .o_vsync  (ovsync),
    .o_hsync  (ohsync),
    .o_valid  (ovalid),
    .o_tdata  (otdata),
    .o_ch     (och)
`ifdef TCONV_PROTO_ERR_EN
    ,
    .o_err    (oerr)
`endif
  );

  always #5 clk = ~clk;

  logic [17:0] wrom [CHANNEL];
  logic [5:0]  col  [SIZE][CHANNEL];
  assign weight = wrom[wch];

  // expected entry: {first_of_row, ch, sum}
  logic [12:0] exp_q [$];
  int errors = 0;
  int checks = 0;
  logic hs_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int tv(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  task automatic push_expect();
    int s, x;
    logic [5:0]  d;
    logic [17:0] w;
    for (int p = 0; p < SIZE; p++)
      for (int c = 0; c < CHANNEL; c++) begin
        s = 0;
        w = wrom[c];
        for (int r = 0; r < 3; r++)
          for (int k = 0; k < 3; k++) begin
            x = p - 1 + k;
            if (x >= 0 && x < SIZE) begin
              d = col[x][c];
              s += tv(d[5-2*r -: 2]) * tv(w[17-2*(3*r+k) -: 2]);
            end
          end
        exp_q.push_back({(p == 0 && c == 0) ? 1'b1 : 1'b0, CW'(c), 5'(s)});
      end
  endtask

  // Monitor: pops one expectation per presented result
  always @(negedge clk) begin
    logic [12:0] e;
    if (ovalid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got ch=%0d sum=%0h with nothing expected", och, otdata);
      end else begin
        e = exp_q.pop_front();
        chk("output{hs,ch,sum}", {19'd0, hs_prev, och, otdata}, {19'd0, e});
      end
    end
    hs_prev = ohsync;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int mode);
    for (int c = 0; c < CHANNEL; c++)
      case (mode)
        0:       wrom[c] = 18'h15555;
        1:       wrom[c] = 18'h00300;
        2:       wrom[c] = 18'h15000;
        default: wrom[c] = 18'($urandom);
      endcase
    for (int p = 0; p < SIZE; p++)
      for (int c = 0; c < CHANNEL; c++)
        case (mode)
          0, 1:    col[p][c] = 6'b010101;
          2:       col[p][c] = 6'b110000;
          default: col[p][c] = 6'($urandom);
        endcase
  endtask

  task automatic drive_row(input bit gaps, input int stop_after, input bit inject,
                           input bit early_hs, input bit skip_hs);
    int n = 0;
    push_expect();
    if (inject) begin
      valid = 1'b1; tdata = 6'($urandom); tick(); valid = 1'b0;
    end
    if (!skip_hs) begin
      hsync = 1'b1; tick(); hsync = 1'b0;
    end
    for (int p = 0; p < SIZE; p++)
      for (int c = 0; c < CHANNEL; c++) begin
        if (n == stop_after) begin
          valid = 1'b0;
          return;
        end
        if (gaps && $urandom_range(3) == 0) begin
          valid = 1'b0; tick();
        end
        valid = 1'b1; tdata = col[p][c]; tick(); n++;
      end
    valid = 1'b0;
    if (inject) begin
      repeat (5) begin
        valid = 1'b1; tdata = 6'($urandom); tick();
      end
      valid = 1'b0;
    end
    if (early_hs) begin
      hsync = 1'b1; tick(); hsync = 1'b0;
    end
    repeat (CHANNEL + 4) tick();
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  task automatic pulse_vsync();
    vsync = 1'b1; tick(); vsync = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vsync = 1'b0; hsync = 1'b0; valid = 1'b0; tdata = '0;
    for (int c = 0; c < CHANNEL; c++) wrom[c] = '0;
    repeat (3) tick();
    chk("rst_valid", ovalid, 0);
    chk("rst_tdata", otdata, 0);
    chk("rst_ch",    och,    0);
    chk("rst_hsync", ohsync, 0);
    chk("rst_vsync", ovsync, 0);
    chk("rst_wch",   wch,    0);
    rst = 1'b0;
    tick();

    // o_vsync is i_vsync three cycles later
    vsync = 1'b1; tick(); vsync = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("vsync_d2", ovsync, 0);
    @(negedge clk); chk("vsync_d3", ovsync, 1);
    @(negedge clk); chk("vsync_d4", ovsync, 0);
    tick();

    fill(0); drive_row(0, -1, 0, 0, 0); wait_drain();
    fill(1); drive_row(0, -1, 0, 0, 0); wait_drain();
    fill(2); drive_row(0, -1, 0, 0, 0); wait_drain();

    // Gapped row with beats in IDLE and FLUSH that must be dropped
    fill(3); drive_row(1, -1, 1, 0, 0); wait_drain();
`ifdef TCONV_PROTO_ERR_EN
    chk("err_set", oerr, 1);
    pulse_vsync(); tick();
    chk("err_clr", oerr, 0);
`else
    pulse_vsync(); tick();
`endif

    // Next row's hsync arrives while the previous row is still flushing
    fill(3); drive_row(0, -1, 0, 1, 0); wait_drain();
    fill(3); drive_row(0, -1, 0, 0, 1); wait_drain();
`ifdef TCONV_PROTO_ERR_EN
    chk("err_quiet", oerr, 0);
`endif

    // Asynchronous reset mid-row, then a clean frame
    fill(3); drive_row(0, 500, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", ovalid, 0);
    chk("mid_rst_tdata", otdata, 0);
    chk("mid_rst_ch",    och,    0);
    chk("mid_rst_wch",   wch,    0);
    exp_q.delete();
    repeat (2) tick();
    rst = 1'b0;
    tick();
    pulse_vsync(); tick();
    fill(3); drive_row(0, -1, 0, 0, 0); wait_drain();
    fill(3); drive_row(1, -1, 0, 0, 0); wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
